// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state, flag struct and iterative-op predicate for alu_seq; ALU_DIV_EN enables opcode 23 DIV
package alu_pkg;
  localparam logic [4:0] OP_ADD = 5'd0, OP_CADD = 5'd1, OP_SUB = 5'd2, OP_BSUB = 5'd3;
  localparam logic [4:0] OP_NEG = 5'd4, OP_INC = 5'd5, OP_DEC = 5'd6, OP_PASS = 5'd7;
  localparam logic [4:0] OP_AND = 5'd8, OP_OR = 5'd9, OP_XOR = 5'd10, OP_COMP = 5'd11;
  localparam logic [4:0] OP_ASL = 5'd12, OP_ASR = 5'd13, OP_LSL = 5'd14, OP_LSR = 5'd15;
  localparam logic [4:0] OP_ROL = 5'd16, OP_ROR = 5'd17, OP_L_CROT = 5'd18, OP_R_CROT = 5'd19;
  localparam logic [4:0] OP_MUL = 5'd20, OP_LSL_N = 5'd21, OP_ASR_N = 5'd22, OP_DIV = 5'd23;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef struct packed {logic carry; logic overflow; logic err;} flags_t;
`ifdef ALU_DIV_EN
  localparam logic DIV_EN = 1'b1;
`else
  localparam logic DIV_EN = 1'b0;
`endif
  function automatic logic is_iter(input logic [4:0] op);
    return op == OP_MUL || op == OP_LSL_N || op == OP_ASR_N || (DIV_EN && op == OP_DIV);
  endfunction
endpackage

// File: rtl/alu_seq_iter.sv
// alu_iter_unit: bit-serial signed MUL, LSL_N/ASR_N and (ALU_DIV_EN) unsigned DIV; loads on start, steps while en, done flags the final step
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             co,
  output logic             ov
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [4:0] op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d, n;
  logic [WIDTH:0] addend, mul_sum;
`ifdef ALU_DIV_EN
  logic [WIDTH:0] div_t;
  logic div_ge;
`endif
  assign done = cnt_q <= CW'(1);
  always_comb begin
    n = (int'(b[SHW-1:0]) > WIDTH) ? CW'(WIDTH) : CW'(b[SHW-1:0]);
    addend = lo_q[0] ? {m_q[WIDTH-1], m_q} : '0;
    mul_sum = (cnt_q == CW'(1)) ? {hi_q[WIDTH-1], hi_q} - addend : {hi_q[WIDTH-1], hi_q} + addend;
`ifdef ALU_DIV_EN
    div_t = {hi_q, lo_q[WIDTH-1]};
    div_ge = div_t >= {1'b0, m_q};
`endif
    res_hi = hi_q;
    res_lo = lo_q;
    co = c_q;
    if (cnt_q != '0)
      case (op_q)
        OP_MUL: begin
          res_hi = mul_sum[WIDTH:1];
          res_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        OP_LSL_N: begin
          res_lo = {lo_q[WIDTH-2:0], 1'b0};
          co = lo_q[WIDTH-1];
        end
        OP_ASR_N: begin
          res_lo = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
          co = lo_q[0];
        end
`ifdef ALU_DIV_EN
        OP_DIV: begin
          res_hi = div_ge ? div_t[WIDTH-1:0] - m_q : div_t[WIDTH-1:0];
          res_lo = {lo_q[WIDTH-2:0], div_ge};
        end
`endif
        default: ;
      endcase
    ov = op_q == OP_MUL && res_hi != {WIDTH{res_lo[WIDTH-1]}};
`ifdef ALU_DIV_EN
    if (op_q == OP_DIV) ov = m_q == '0;
`endif
    op_d = op_q;
    hi_d = hi_q;
    lo_d = lo_q;
    m_d = m_q;
    c_d = c_q;
    cnt_d = cnt_q;
    if (start) begin
      op_d = op;
      hi_d = '0;
      c_d = 1'b0;
      m_d = op == OP_MUL ? a : b;
      lo_d = op == OP_MUL ? b : a;
      cnt_d = (op == OP_LSL_N || op == OP_ASR_N) ? n : (is_iter(op) ? CW'(WIDTH) : '0);
    end else if (en) begin
      hi_d = res_hi;
      lo_d = res_lo;
      c_d = co;
      cnt_d = cnt_q - CW'(cnt_q != '0);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      c_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      op_q <= op_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q <= m_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready WIDTH-bit signed ALU, 20 single-cycle ops plus iterative MUL/LSL_N/ASR_N and DIV when ALU_DIV_EN is defined
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             err
);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, result_hi_q, result_hi_d;
  logic [WIDTH-1:0] sc_r, it_lo, it_hi;
  logic ci_q, ci_d, sc_c, sc_v, sc_e, it_done, it_co, it_ov;
  logic [WIDTH:0] sum, dif;
  flags_t flags_q, flags_d;
  alu_iter_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk(clk), .rst_n(rst_n), .start(state_q == IDLE && in_valid), .en(state_q == EXEC),
    .op(opcode), .a(operand_a), .b(operand_b),
    .done(it_done), .res_lo(it_lo), .res_hi(it_hi), .co(it_co), .ov(it_ov)
  );
  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, op_q == OP_CADD && ci_q};
    dif = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, op_q == OP_BSUB && ci_q};
    sc_r = '0;
    sc_c = 1'b0;
    sc_v = 1'b0;
    sc_e = 1'b0;
    case (op_q)
      OP_ADD, OP_CADD: begin
        sc_r = sum[WIDTH-1:0];
        sc_c = sum[WIDTH];
        sc_v = a_q[WIDTH-1] == b_q[WIDTH-1] && sum[WIDTH-1] != a_q[WIDTH-1];
      end
      OP_SUB, OP_BSUB: begin
        sc_r = dif[WIDTH-1:0];
        sc_c = dif[WIDTH];
        sc_v = a_q[WIDTH-1] != b_q[WIDTH-1] && dif[WIDTH-1] != a_q[WIDTH-1];
      end
      OP_NEG: begin
        sc_r = '0 - a_q;
        sc_v = a_q == MIN;
      end
      OP_INC: begin
        sc_r = a_q + WIDTH'(1);
        sc_v = a_q == ~MIN;
      end
      OP_DEC: begin
        sc_r = a_q - WIDTH'(1);
        sc_v = a_q == MIN;
      end
      OP_PASS: sc_r = a_q;
      OP_AND: sc_r = a_q & b_q;
      OP_OR: sc_r = a_q | b_q;
      OP_XOR: sc_r = a_q ^ b_q;
      OP_COMP: sc_r = ~a_q;
      OP_ASL, OP_LSL: begin
        sc_r = {a_q[WIDTH-2:0], 1'b0};
        sc_c = a_q[WIDTH-1];
      end
      OP_ASR: begin
        sc_r = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        sc_c = a_q[0];
      end
      OP_LSR: begin
        sc_r = {1'b0, a_q[WIDTH-1:1]};
        sc_c = a_q[0];
      end
      OP_ROL: sc_r = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
      OP_ROR: sc_r = {a_q[0], a_q[WIDTH-1:1]};
      OP_L_CROT: begin
        sc_r = {a_q[WIDTH-2:0], ci_q};
        sc_c = a_q[WIDTH-1];
      end
      OP_R_CROT: begin
        sc_r = {ci_q, a_q[WIDTH-1:1]};
        sc_c = a_q[0];
      end
      default: sc_e = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    ci_d = ci_q;
    result_d = result_q;
    result_hi_d = result_hi_q;
    flags_d = flags_q;
    case (state_q)
      IDLE:
        if (in_valid) begin
          state_d = EXEC;
          op_d = opcode;
          a_d = operand_a;
          b_d = operand_b;
          ci_d = carry_in;
          flags_d.err = 1'b0;
        end
      EXEC:
        if (!is_iter(op_q) || it_done) begin
          state_d = DONE;
          result_d = is_iter(op_q) ? it_lo : sc_r;
          result_hi_d = is_iter(op_q) ? it_hi : '0;
          flags_d = is_iter(op_q) ? {it_co, it_ov, 1'b0} : {sc_c, sc_v, sc_e};
        end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      ci_q <= 1'b0;
      result_q <= '0;
      result_hi_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      ci_q <= ci_d;
      result_q <= result_d;
      result_hi_q <= result_hi_d;
      flags_q <= flags_d;
    end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result = result_q;
  assign result_hi = result_hi_q;
  assign carry_out = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign err = flags_q.err;
  assign zero = result_q == '0;
  assign negative = result_q[WIDTH-1];
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven and hand-sequenced self-checking bench for alu_seq at WIDTH=8
module tb_alu_seq;
  import alu_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, carry_in = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, carry_out, overflow, zero, negative, err;
  logic [4:0] opcode = '0;
  logic [7:0] operand_a = '0, operand_b = '0, result, result_hi;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [4:0] op;
    logic [7:0] a, b;
    logic ci;
    logic [7:0] r, hi;
    logic c, v, e;
    int lat;
  } vec_t;
  vec_t vecs[$];
  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_hi(result_hi), .carry_out(carry_out),
    .overflow(overflow), .zero(zero), .negative(negative), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic vec(input logic [4:0] op, input logic [7:0] a, b, input logic ci,
                     input logic [7:0] r, hi, input logic c, v, e, input int lat);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.ci = ci; t.r = r; t.hi = hi; t.c = c; t.v = v; t.e = e; t.lat = lat;
    vecs.push_back(t);
  endtask
  task automatic issue(input logic [4:0] op, input logic [7:0] a, b, input logic ci);
    @(negedge clk);
    opcode = op; operand_a = a; operand_b = b; carry_in = ci; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 40);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    logic seen;
    vec(OP_ADD,    8'h64, 8'h32, 0, 8'h96, 8'h00, 0, 1, 0, 1);
    vec(OP_CADD,   8'hFF, 8'h01, 1, 8'h01, 8'h00, 1, 0, 0, 1);
    vec(OP_SUB,    8'h00, 8'h01, 0, 8'hFF, 8'h00, 1, 0, 0, 1);
    vec(OP_SUB,    8'h80, 8'h01, 0, 8'h7F, 8'h00, 0, 1, 0, 1);
    vec(OP_BSUB,   8'h05, 8'h03, 1, 8'h01, 8'h00, 0, 0, 0, 1);
    vec(OP_NEG,    8'h80, 8'h00, 0, 8'h80, 8'h00, 0, 1, 0, 1);
    vec(OP_NEG,    8'h05, 8'h00, 0, 8'hFB, 8'h00, 0, 0, 0, 1);
    vec(OP_INC,    8'h7F, 8'h00, 0, 8'h80, 8'h00, 0, 1, 0, 1);
    vec(OP_DEC,    8'h80, 8'h00, 0, 8'h7F, 8'h00, 0, 1, 0, 1);
    vec(OP_PASS,   8'hA7, 8'h00, 0, 8'hA7, 8'h00, 0, 0, 0, 1);
    vec(OP_AND,    8'hF0, 8'h3C, 0, 8'h30, 8'h00, 0, 0, 0, 1);
    vec(OP_OR,     8'h0F, 8'h30, 0, 8'h3F, 8'h00, 0, 0, 0, 1);
    vec(OP_XOR,    8'hF0, 8'h3C, 0, 8'hCC, 8'h00, 0, 0, 0, 1);
    vec(OP_COMP,   8'h5A, 8'h00, 0, 8'hA5, 8'h00, 0, 0, 0, 1);
    vec(OP_ASL,    8'h81, 8'h00, 0, 8'h02, 8'h00, 1, 0, 0, 1);
    vec(OP_ASR,    8'h81, 8'h00, 0, 8'hC0, 8'h00, 1, 0, 0, 1);
    vec(OP_LSL,    8'h41, 8'h00, 0, 8'h82, 8'h00, 0, 0, 0, 1);
    vec(OP_LSR,    8'h81, 8'h00, 0, 8'h40, 8'h00, 1, 0, 0, 1);
    vec(OP_ROL,    8'h81, 8'h00, 0, 8'h03, 8'h00, 0, 0, 0, 1);
    vec(OP_ROR,    8'h81, 8'h00, 0, 8'hC0, 8'h00, 0, 0, 0, 1);
    vec(OP_L_CROT, 8'h40, 8'h00, 1, 8'h81, 8'h00, 0, 0, 0, 1);
    vec(OP_R_CROT, 8'h01, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 1);
    vec(OP_MUL,    8'hFD, 8'h05, 0, 8'hF1, 8'hFF, 0, 0, 0, 8);
    vec(OP_MUL,    8'h10, 8'h10, 0, 8'h00, 8'h01, 0, 1, 0, 8);
    vec(OP_MUL,    8'h80, 8'h80, 0, 8'h00, 8'h40, 0, 1, 0, 8);
    vec(OP_MUL,    8'h80, 8'hFF, 0, 8'h80, 8'h00, 0, 1, 0, 8);
    vec(OP_MUL,    8'hF9, 8'hFA, 0, 8'h2A, 8'h00, 0, 0, 0, 8);
    vec(OP_ASR_N,  8'h80, 8'h03, 0, 8'hF0, 8'h00, 0, 0, 0, 3);
    vec(OP_ASR_N,  8'h81, 8'h02, 0, 8'hE0, 8'h00, 0, 0, 0, 2);
    vec(OP_ASR_N,  8'h80, 8'h0F, 0, 8'hFF, 8'h00, 1, 0, 0, 8);
    vec(OP_LSL_N,  8'h81, 8'h09, 0, 8'h00, 8'h00, 1, 0, 0, 8);
    vec(OP_LSL_N,  8'h5A, 8'h00, 0, 8'h5A, 8'h00, 0, 0, 0, 1);
    vec(OP_LSL_N,  8'h03, 8'h11, 0, 8'h06, 8'h00, 0, 0, 0, 1);
    vec(5'd24,     8'h12, 8'h34, 0, 8'h00, 8'h00, 0, 0, 1, 1);
    vec(5'd31,     8'hFF, 8'hFF, 1, 8'h00, 8'h00, 0, 0, 1, 1);
`ifdef ALU_DIV_EN
    vec(OP_DIV,    8'hC8, 8'h07, 0, 8'h1C, 8'h04, 0, 0, 0, 8);
    vec(OP_DIV,    8'h5A, 8'h00, 0, 8'hFF, 8'h5A, 0, 1, 0, 8);
`else
    vec(OP_DIV,    8'hC8, 8'h07, 0, 8'h00, 8'h00, 0, 0, 1, 1);
`endif
    #12;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset result_hi", result_hi, 0);
    chk("reset flags", {carry_out, overflow, err}, 0);
    @(negedge clk) rst_n = 1'b1;
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci);
      wait_out(lat);
      chk($sformatf("v%0d op%0d latency", i, vecs[i].op), lat, vecs[i].lat);
      chk($sformatf("v%0d op%0d result", i, vecs[i].op), result, vecs[i].r);
      chk($sformatf("v%0d op%0d result_hi", i, vecs[i].op), result_hi, vecs[i].hi);
      chk($sformatf("v%0d op%0d carry_out", i, vecs[i].op), carry_out, vecs[i].c);
      chk($sformatf("v%0d op%0d overflow", i, vecs[i].op), overflow, vecs[i].v);
      chk($sformatf("v%0d op%0d err", i, vecs[i].op), err, vecs[i].e);
      chk($sformatf("v%0d op%0d zero", i, vecs[i].op), zero, vecs[i].r == 8'h00);
      chk($sformatf("v%0d op%0d negative", i, vecs[i].op), negative, vecs[i].r[7]);
      @(posedge clk);
      #1 chk($sformatf("v%0d op%0d in_ready after handshake", i, vecs[i].op), in_ready, 1);
    end
    out_ready = 1'b0;
    issue(OP_ADD, 8'h11, 8'h22, 1'b0);
    wait_out(lat);
    chk("bp latency", lat, 1);
    @(negedge clk);
    opcode = OP_XOR; operand_a = 8'hFF; operand_b = 8'h0F; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1 chk("bp held result", result, 8'h33);
      chk("bp held out_valid", out_valid, 1);
      chk("bp in_ready low", in_ready, 0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp handshake in_ready", in_ready, 1);
    chk("bp handshake out_valid", out_valid, 0);
    @(posedge clk);
    #1 chk("bp next accepted", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("bp next out_valid", out_valid, 1);
    chk("bp next result", result, 8'hF0);
    @(posedge clk);
    issue(5'd25, 8'h01, 8'h02, 1'b0);
    wait_out(lat);
    chk("illegal err", err, 1);
    @(posedge clk);
    #1 chk("err held in idle", err, 1);
    issue(OP_MUL, 8'h07, 8'h03, 1'b0);
    chk("err cleared on accept", err, 0);
    wait_out(lat);
    chk("mul 7*3 latency", lat, 8);
    chk("mul 7*3 result", result, 8'h15);
    @(posedge clk);
    issue(OP_MUL, 8'hFD, 8'h05, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort result", result, 0);
    chk("abort result_hi", result_hi, 0);
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    chk("abort flags", {carry_out, overflow, err}, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 seen = seen | out_valid;
    end
    chk("abort no out_valid", seen, 0);
    issue(OP_ADD, 8'h01, 8'h01, 1'b0);
    wait_out(lat);
    chk("post-reset add", result, 8'h02);
    @(posedge clk);
    #1 $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
